// File: rtl/mux16_arb_pkg.sv
// mux16_arb_pkg: shared constants, state type and one-hot helper for the 16-way arbiter
package mux16_arb_pkg;
  localparam int NREQ = 16;
  localparam int SELW = 4;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [15:0] onehot16(input logic [3:0] i);
    return 16'(1) << i;
  endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: combinational round-robin pick starting just after ptr, ptr itself searched last
module rr_pick16 (
  input  logic [15:0] req,
  input  logic [3:0]  ptr,
  output logic        valid,
  output logic [3:0]  idx
);
  logic [3:0] s, off;
  logic [31:0] dbl;
  logic [15:0] rot;
  assign s = ptr + 4'd1;
  assign dbl = {req, req} >> s;
  assign rot = dbl[15:0];
  assign valid = |req;
  assign idx = s + off;
  // lowest set bit of the rotated vector is the first requester after ptr
  always_comb begin
    off = '0;
    for (int i = 15; i >= 0; i--) if (rot[i]) off = 4'(i);
  end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner of the 16:1 mux select with bounded hold time
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [SELW-1:0]  sel,
  output logic             busy,
  output logic             timeout
);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  state_t fsm;
  logic [SELW-1:0] owner, ptr, idx;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] pick_req;
  logic valid, early, at_max, rel;
  assign early = done | ~req[owner];
  assign at_max = cnt == CW'(MAX_HOLD - 1);
  assign rel = fsm == BUSY && (early || at_max);
  assign pick_req = (fsm == BUSY && early) ? req & ~onehot16(owner) : req;
  rr_pick16 u_pick (
    .req(pick_req),
    .ptr(ptr),
    .valid(valid),
    .idx(idx)
  );
  // grant fsm: re-pick when idle or on release, otherwise extend the hold
  always_ff @(posedge clk)
    if (rst) begin
      fsm <= IDLE;
      owner <= '0;
      ptr <= 4'd15;
      cnt <= '0;
      gnt <= '0;
      sel <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= rel && !early;
      if (fsm == IDLE || rel) begin
        fsm <= valid ? BUSY : IDLE;
        busy <= valid;
        gnt <= valid ? onehot16(idx) : '0;
        cnt <= '0;
        if (valid) begin
          sel <= idx;
          owner <= idx;
          ptr <= idx;
        end
      end else cnt <= cnt + 1'b1;
    end
endmodule
